// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter that shares one I2C master engine among NUM_REQ requesters,
// latching the winner's command and supervising completion with a timeout watchdog.
module i2c_txn_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 4096,
    parameter int TW          = 13
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ-1:0]     req_rw,
    input  logic [7*NUM_REQ-1:0]   req_dev,
    input  logic [8*NUM_REQ-1:0]   req_reg,
    input  logic [8*NUM_REQ-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]     grant,
    output logic [NUM_REQ-1:0]     done,
    output logic [7:0]             rdata,
    output logic [1:0]             err,
    output logic                   m_start,
    output logic                   m_rw,
    output logic [6:0]             m_dev,
    output logic [7:0]             m_reg,
    output logic [7:0]             m_wdata,
    input  logic                   m_busy,
    input  logic                   m_done,
    input  logic                   m_nack,
    input  logic [7:0]             m_rdata,
    output logic                   m_abort
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ARB   = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        RESP  = 3'd4
    } state_t;

    state_t               state_q;
    logic [PW-1:0]        ptr_q;
    logic [TW-1:0]        timeoutCnt_q;
    logic [NUM_REQ-1:0]   grant_q;
    logic [NUM_REQ-1:0]   done_q;
    logic [7:0]           rdata_q;
    logic [1:0]           err_q;
    logic                 mStart_q;
    logic                 mAbort_q;
    logic                 mRw_q;
    logic [6:0]           mDev_q;
    logic [7:0]           mReg_q;
    logic [7:0]           mWdata_q;

    logic                 found_d;
    logic [PW-1:0]        win_d;
    logic [PW-1:0]        ptr_d;
    logic                 winRw_d;
    logic [6:0]           winDev_d;
    logic [7:0]           winReg_d;
    logic [7:0]           winWdata_d;

    // The master accepts m_start whenever idle, and the FSM never issues while a
    // transaction is outstanding, so busy carries no decision here.
    logic                 unusedBusy;
    assign unusedBusy = m_busy;

    function automatic logic [PW-1:0] wrapIdx(input logic [PW-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return PW'(s);
    endfunction

    always_comb begin
        found_d = 1'b0;
        win_d   = ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found_d && req[wrapIdx(ptr_q, k)]) begin
                found_d = 1'b1;
                win_d   = wrapIdx(ptr_q, k);
            end
        end
        ptr_d = (win_d == PW'(NUM_REQ - 1)) ? '0 : win_d + 1'b1;
    end

    always_comb begin
        winRw_d    = 1'b0;
        winDev_d   = '0;
        winReg_d   = '0;
        winWdata_d = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_d == PW'(i)) begin
                winRw_d    = req_rw[i];
                winDev_d   = req_dev[7*i +: 7];
                winReg_d   = req_reg[8*i +: 8];
                winWdata_d = req_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            timeoutCnt_q <= '0;
            grant_q      <= '0;
            done_q       <= '0;
            rdata_q      <= '0;
            err_q        <= '0;
            mStart_q     <= 1'b0;
            mAbort_q     <= 1'b0;
            mRw_q        <= 1'b0;
            mDev_q       <= '0;
            mReg_q       <= '0;
            mWdata_q     <= '0;
        end else begin
            mStart_q <= 1'b0;
            mAbort_q <= 1'b0;
            done_q   <= '0;
            case (state_q)
                IDLE: begin
                    if (|req) state_q <= ARB;
                end
                ARB: begin
                    if (found_d) begin
                        grant_q  <= NUM_REQ'(1) << win_d;
                        mRw_q    <= winRw_d;
                        mDev_q   <= winDev_d;
                        mReg_q   <= winReg_d;
                        mWdata_q <= winWdata_d;
                        ptr_q    <= ptr_d;
                        state_q  <= ISSUE;
                    end else begin
                        state_q  <= IDLE;
                    end
                end
                ISSUE: begin
                    mStart_q     <= 1'b1;
                    timeoutCnt_q <= '0;
                    state_q      <= WAIT;
                end
                // Completion takes priority over the watchdog on the terminal cycle.
                WAIT: begin
                    if (m_done) begin
                        rdata_q <= mRw_q ? m_rdata : 8'h00;
                        err_q   <= m_nack ? 2'b01 : 2'b00;
                        done_q  <= grant_q;
                        state_q <= RESP;
                    end else if (timeoutCnt_q == TW'(TIMEOUT_CYC - 1)) begin
                        mAbort_q <= 1'b1;
                        rdata_q  <= 8'h00;
                        err_q    <= 2'b10;
                        done_q   <= grant_q;
                        state_q  <= RESP;
                    end else begin
                        timeoutCnt_q <= timeoutCnt_q + 1'b1;
                    end
                end
                RESP: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
                default: begin
                    grant_q <= '0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign grant   = grant_q;
    assign done    = done_q;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign m_start = mStart_q;
    assign m_abort = mAbort_q;
    assign m_rw    = mRw_q;
    assign m_dev   = mDev_q;
    assign m_reg   = mReg_q;
    assign m_wdata = mWdata_q;

endmodule

// File: doc/i2c_txn_arbiter.md
Name: i2c_txn_arbiter

Overview:
- Shares a single I2C master engine among NUM_REQ requesters. Each requester asks for one register transaction: a write, or a write-address-then-repeated-start read.
- Round-robin arbitration; latches the winner's command and drives the master's start/command interface.
- Waits for master completion, with a timeout watchdog, and returns read data, NACK status and a per-requester done pulse.
- Sits between system-side clients (config FSMs, CPU bridge) and the bit-level I2C master that drives scl/sda.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 4096, clk cycles allowed from start issue to master done before abort.
- TW, 13, timeout counter width; must satisfy 2^TW > TIMEOUT_CYC.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request level; held high until the matching done pulse.
- req_rw  input  NUM_REQ  per-requester direction: 1 = read, 0 = write.
- req_dev  input  7*NUM_REQ  packed 7-bit device addresses; requester i uses [7i+6:7i].
- req_reg  input  8*NUM_REQ  packed register addresses.
- req_wdata  input  8*NUM_REQ  packed write data.
- grant  output  NUM_REQ  one-hot owner of the current transaction; all zero when idle.
- done  output  NUM_REQ  one-cycle completion pulse to the owner.
- rdata  output  8  read data, valid with done; 0 after a write.
- err  output  2  valid with done: 00 ok, 01 NACK, 10 timeout.
- m_start  output  1  one-cycle pulse to the master: begin transaction.
- m_rw  output  1  latched direction.
- m_dev  output  7  latched device address.
- m_reg  output  8  latched register address.
- m_wdata  output  8  latched write data.
- m_busy  input  1  master busy.
- m_done  input  1  master one-cycle completion pulse.
- m_nack  input  1  master saw NACK; valid with m_done.
- m_rdata  input  8  master read byte; valid with m_done.
- m_abort  output  1  one-cycle pulse: master must release the bus and generate STOP.

Behaviour:
- Reset: all outputs 0, FSM = IDLE, round-robin pointer = 0, timeout counter = 0.
  - Reset mid-transaction aborts with no done pulse and no m_abort.
  - The master has its own reset and is not sequenced by this block.
- FSM states:
  - IDLE: if any req bit is set, go to ARB next cycle.
  - ARB: select the first set req bit searching from pointer upward, with wrap. Set grant one-hot. Latch m_rw/m_dev/m_reg/m_wdata from the winner's slices. Pointer <= winner+1 mod NUM_REQ. Go to ISSUE. If req dropped to all-zero, return to IDLE.
  - ISSUE: m_start=1 for exactly one cycle; clear the timeout counter; go to WAIT.
  - WAIT: increment the timeout counter each cycle.
    - On m_done: capture m_nack and m_rdata (rdata forced 0 if m_rw=0); go to RESP.
    - Else if the counter reaches TIMEOUT_CYC-1: m_abort=1 for one cycle; err=10; go to RESP.
    - m_done in the same cycle as terminal count: m_done wins, no abort.
  - RESP: done[winner]=1 for one cycle, with rdata/err valid the same cycle. grant clears on the next cycle. Go to IDLE.
  - rdata/err hold their value until the next RESP.
- Latency: req rising in IDLE gives grant at +2 clk and m_start at +3 clk.
- Fairness: the pointer advances only on grant, so a requester waits at most NUM_REQ-1 transactions.
- Latching: command fields are latched once in ARB. Requester changes to its fields after grant are ignored.
- Requester drops req mid-transaction: the transaction completes normally and done is still pulsed.
- m_done outside WAIT: ignored.
- m_busy is informational only. ISSUE does not wait on it, because the master must accept m_start whenever it is idle and the arbiter guarantees that by sequencing.
- Illegal or unknown state: return to IDLE.

Test Plan:
- Single write: req[1]=1, rw=0, dev=0x50, reg=0x10, wdata=0xA5. Expect grant=0010 at +2 and m_start at +3 with fields matching. Master m_done with nack=0 after 20 clk. Expect done[1] pulse, err=00, rdata=00.
- Read: req[2]=1, rw=1. Master returns m_rdata=0x3C. Expect done[2] with rdata=0x3C, err=00. Then m_nack=1 on a second read: expect err=01.
- Round-robin: req=1111 held, each transaction completed. Expect grant order 0001,0010,0100,1000,0001. Also pointer=2 with req=0011: expect order 0001, then 0010.
- Timeout: TIMEOUT_CYC=16, master never sends done. Expect m_abort pulse 16 clk after m_start, then done with err=10, then grant=0.
- Boundary collision: m_done on the exact terminal-count cycle. Expect err from m_nack and no m_abort.
- Reset mid-WAIT: assert rst for 1 clk. Expect grant=0, no done pulse, pointer=0, and the next request granted from requester 0 first.
